// File: rtl/hf_tree_loader.sv
`default_nettype none
// ============================================================================
// Module   : hf_tree_loader
// Purpose  : Serial Huffman tree-descriptor parser for the 4-bit-symbol
//            decompressor. The block:
//              - hunts the bitstream for the SYNC marker;
//              - parses the leaf count and the leaf descriptors;
//              - programs the 16-entry leaf table through a write port;
//              - forwards payload bits to the decoder once the table is
//                complete.
// Options  : HF_TREE_LENCHK_EN - when defined, a leaf length above MAX_LEN
//            sends the parser to a sticky error state. When not defined,
//            every length 1..16 is accepted and err stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module hf_tree_loader #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         MAX_LEN = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        restart,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        wr_en,
  output logic [3:0]  wr_idx,
  output logic [15:0] wr_code,
  output logic [4:0]  wr_len,
  output logic [3:0]  wr_value,
  output logic        tree_ready,
  output logic        dec_bit,
  output logic        dec_valid,
  output logic        err
);

  // MAX_LEN must describe a length the 4-bit LEN field can encode.
  if (MAX_LEN < 1 || MAX_LEN > 16) begin : g_bad_max_len
    $error("hf_tree_loader: MAX_LEN must be in 1..16");
  end

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    COUNT  = 3'd1,
    VALUE  = 3'd2,
    LENGTH = 3'd3,
    CODE   = 3'd4,
    READY  = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t      state_q;
  logic [7:0]  sh_q;        // sync hunt shift register
  logic [3:0]  fld_q;       // 4-bit field accumulator (CNT / VAL / LEN)
  logic [4:0]  bitcnt_q;    // bits collected in the current field
  logic [3:0]  left_q;      // leaves remaining after the current one
  logic [3:0]  val_q;
  logic [4:0]  len_q;       // decoded length, 1..16
  logic [15:0] code_q;
  logic [3:0]  idx_q;       // next leaf slot

  logic        wr_en_q;
  logic [3:0]  wr_idx_q;
  logic [15:0] wr_code_q;
  logic [4:0]  wr_len_q;
  logic [3:0]  wr_value_q;
  logic        tree_ready_q;

  // Values each register takes if the current bit is shifted in.
  logic [7:0]  sh_d;
  logic [3:0]  fld_d;
  logic [15:0] code_d;
  logic [4:0]  len_d;
  logic        len_bad_d;

  assign sh_d   = {sh_q[6:0], bit_in};
  assign fld_d  = {fld_q[2:0], bit_in};
  assign code_d = {code_q[14:0], bit_in};
  assign len_d  = {1'b0, fld_d} + 5'd1;

`ifdef HF_TREE_LENCHK_EN
  localparam logic [5:0] c_MAX_LEN = 6'(MAX_LEN);
  assign len_bad_d = ({1'b0, len_d} > c_MAX_LEN);
  // The error flag is simply "parked in ERR"; it is sticky until restart/Reset.
  assign err       = (state_q == ERR);
`else
  assign len_bad_d = 1'b0;
  assign err       = 1'b0;
`endif

  assign wr_en      = wr_en_q;
  assign wr_idx     = wr_idx_q;
  assign wr_code    = wr_code_q;
  assign wr_len     = wr_len_q;
  assign wr_value   = wr_value_q;
  assign tree_ready = tree_ready_q;
  assign dec_bit    = bit_in;
  assign dec_valid  = bit_valid & tree_ready_q;

  // Parser FSM with registered table-write and ready outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= HUNT;
      sh_q         <= 8'd0;
      fld_q        <= 4'd0;
      bitcnt_q     <= 5'd0;
      left_q       <= 4'd0;
      val_q        <= 4'd0;
      len_q        <= 5'd0;
      code_q       <= 16'd0;
      idx_q        <= 4'd0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= 4'd0;
      wr_code_q    <= 16'd0;
      wr_len_q     <= 5'd0;
      wr_value_q   <= 4'd0;
      tree_ready_q <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse.
      wr_en_q <= 1'b0;
      if (restart) begin
        // Restart wins over any bit presented in the same cycle.
        state_q      <= HUNT;
        sh_q         <= 8'd0;
        fld_q        <= 4'd0;
        bitcnt_q     <= 5'd0;
        left_q       <= 4'd0;
        val_q        <= 4'd0;
        len_q        <= 5'd0;
        code_q       <= 16'd0;
        idx_q        <= 4'd0;
        tree_ready_q <= 1'b0;
      end else if (bit_valid) begin
        case (state_q)
          HUNT: begin
            sh_q <= sh_d;
            if (sh_d == SYNC) begin
              state_q  <= COUNT;
              bitcnt_q <= 5'd0;
            end
          end
          COUNT: begin
            fld_q <= fld_d;
            if (bitcnt_q == 5'd3) begin
              left_q   <= fld_d;
              bitcnt_q <= 5'd0;
              state_q  <= VALUE;
            end else begin
              bitcnt_q <= bitcnt_q + 5'd1;
            end
          end
          VALUE: begin
            fld_q <= fld_d;
            if (bitcnt_q == 5'd3) begin
              val_q    <= fld_d;
              bitcnt_q <= 5'd0;
              state_q  <= LENGTH;
            end else begin
              bitcnt_q <= bitcnt_q + 5'd1;
            end
          end
          LENGTH: begin
            fld_q <= fld_d;
            if (bitcnt_q == 5'd3) begin
              len_q    <= len_d;
              code_q   <= 16'd0;
              bitcnt_q <= 5'd0;
              // An over-long leaf is dropped without a table write.
              if (len_bad_d) begin
                state_q <= ERR;
              end else begin
                state_q <= CODE;
              end
            end else begin
              bitcnt_q <= bitcnt_q + 5'd1;
            end
          end
          CODE: begin
            code_q <= code_d;
            if (bitcnt_q + 5'd1 == len_q) begin
              wr_en_q    <= 1'b1;
              wr_idx_q   <= idx_q;
              wr_code_q  <= code_d;
              wr_len_q   <= len_q;
              wr_value_q <= val_q;
              idx_q      <= idx_q + 4'd1;
              bitcnt_q   <= 5'd0;
              // left_q holds CNT-style "remaining minus one", so zero means last.
              if (left_q == 4'd0) begin
                state_q      <= READY;
                tree_ready_q <= 1'b1;
              end else begin
                left_q  <= left_q - 4'd1;
                state_q <= VALUE;
              end
            end else begin
              bitcnt_q <= bitcnt_q + 5'd1;
            end
          end
          READY: begin
            state_q <= READY;
          end
          ERR: begin
            state_q <= ERR;
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hf_tree_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hf_tree_loader
// Purpose  : Scoreboard bench for hf_tree_loader. Directed streams push the
//            expected leaf-table writes and payload bits into queues. A
//            negedge monitor pops and compares them whenever the DUT strobes
//            wr_en or dec_valid.
// Options  : HF_TREE_LENCHK_EN selects the length-check scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hf_tree_loader;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        restart = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [15:0] wr_code;
  logic [4:0]  wr_len;
  logic [3:0]  wr_value;
  logic        tree_ready;
  logic        dec_bit;
  logic        dec_valid;
  logic        err;

  hf_tree_loader #(.SYNC(8'hA5), .MAX_LEN(8)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .restart    (restart),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_code    (wr_code),
    .wr_len     (wr_len),
    .wr_value   (wr_value),
    .tree_ready (tree_ready),
    .dec_bit    (dec_bit),
    .dec_valid  (dec_valid),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] code;
    logic [4:0]  len;
    logic [3:0]  val;
    logic        last;
  } wr_t;

  wr_t  exp_q[$];
  logic dec_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   next_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every write strobe and every forwarded bit.
  always @(negedge CLK) begin
    wr_t e;
    if (Reset) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_en", {31'd0, wr_en}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_idx", {28'd0, wr_idx}, {28'd0, e.idx});
          chk("wr_code", {16'd0, wr_code}, {16'd0, e.code});
          chk("wr_len", {27'd0, wr_len}, {27'd0, e.len});
          chk("wr_value", {28'd0, wr_value}, {28'd0, e.val});
          chk("tree_ready_at_wr", {31'd0, tree_ready}, {31'd0, e.last});
        end
      end
      if (dec_valid) begin
        if (dec_q.size() == 0) begin
          chk("unexpected_dec_valid", {31'd0, dec_valid}, 32'd0);
        end else begin
          chk("dec_bit", {31'd0, dec_bit}, {31'd0, dec_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  // Send the n low bits of v MSB first; gap inserts idle cycles mid-field.
  task automatic put_bits(input logic [15:0] v, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      put_bit(v[i]);
      if (gap && (i % 3 == 1)) tick();
    end
  endtask

  task automatic send_hdr(input logic [3:0] cntf, input bit gap);
    put_bits(16'h00A5, 8, gap);
    put_bits({12'd0, cntf}, 4, gap);
    next_idx = 0;
  endtask

  task automatic send_leaf(input logic [3:0] val, input logic [3:0] lenf,
                           input logic [15:0] code, input bit last, input bit gap);
    wr_t e;
    e.idx  = 4'(next_idx);
    e.code = code;
    e.len  = {1'b0, lenf} + 5'd1;
    e.val  = val;
    e.last = last;
    exp_q.push_back(e);
    next_idx++;
    put_bits({12'd0, val}, 4, gap);
    put_bits({12'd0, lenf}, 4, gap);
    put_bits(code, int'(lenf) + 1, gap);
  endtask

  task automatic send_payload(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      dec_q.push_back(v[i]);
      put_bit(v[i]);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    #3;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_idx", {28'd0, wr_idx}, 32'd0);
    chk("rst_wr_code", {16'd0, wr_code}, 32'd0);
    chk("rst_wr_len", {27'd0, wr_len}, 32'd0);
    chk("rst_wr_value", {28'd0, wr_value}, 32'd0);
    chk("rst_tree_ready", {31'd0, tree_ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    tick();
    Reset = 1'b1;
    tick();

    // Two-leaf tree, back-to-back, then payload.
    send_hdr(4'b0001, 1'b0);
    send_leaf(4'd3, 4'b0000, 16'h0000, 1'b0, 1'b0);
    send_leaf(4'd9, 4'b0001, 16'h0002, 1'b1, 1'b0);
    send_payload(16'h00D2, 8);
    tick();
    chk("ready_after_tree1", {31'd0, tree_ready}, 32'd1);

    // Noise, an overlapping prefix and bit_valid gaps give the same result.
    do_restart();
    chk("ready_cleared_by_restart", {31'd0, tree_ready}, 32'd0);
    put_bits(16'h005A, 8, 1'b1);
    put_bits(16'h00FF, 8, 1'b0);
    put_bits(16'h000A, 4, 1'b1);
    send_hdr(4'b0001, 1'b1);
    send_leaf(4'd3, 4'b0000, 16'h0000, 1'b0, 1'b1);
    send_leaf(4'd9, 4'b0001, 16'h0002, 1'b1, 1'b1);
    send_payload(16'h0005, 4);
    tick();

    // Sixteen leaves of length 4; ready only with the idx15 write.
    do_restart();
    send_hdr(4'b1111, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_leaf(4'(i), 4'd3, 16'(15 - i), (i == 15), 1'b0);
    end
    send_payload(16'h0003, 2);
    tick();

    // Length boundaries.
    do_restart();
`ifdef HF_TREE_LENCHK_EN
    send_hdr(4'b0000, 1'b0);
    send_leaf(4'd7, 4'd7, 16'h00A7, 1'b1, 1'b0);
    tick();
    // LEN=1000 (length 9) exceeds MAX_LEN=8.
    do_restart();
    send_hdr(4'b0000, 1'b0);
    put_bits(16'h0005, 4, 1'b0);
    put_bits(16'h0008, 4, 1'b0);
    put_bits(16'h01FF, 9, 1'b0);
    tick();
    chk("err_on_long_len", {31'd0, err}, 32'd1);
    chk("ready_low_in_err", {31'd0, tree_ready}, 32'd0);
    do_restart();
    chk("err_cleared_by_restart", {31'd0, err}, 32'd0);
    send_hdr(4'b0000, 1'b0);
    send_leaf(4'd1, 4'd2, 16'h0005, 1'b1, 1'b0);
    tick();
`else
    send_hdr(4'b0010, 1'b0);
    send_leaf(4'd7, 4'd15, 16'hBEEF, 1'b0, 1'b0);
    send_leaf(4'hC, 4'd8, 16'h01A5, 1'b0, 1'b0);
    send_leaf(4'd7, 4'd7, 16'h00A7, 1'b1, 1'b0);
    tick();
    chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

    // Restart together with a CODE bit: bit dropped, next tree from idx0.
    do_restart();
    send_hdr(4'b0000, 1'b0);
    put_bits(16'h0006, 4, 1'b0);
    put_bits(16'h0003, 4, 1'b0);
    put_bits(16'h0003, 2, 1'b0);
    restart   = 1'b1;
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    tick();
    restart   = 1'b0;
    bit_valid = 1'b0;
    chk("ready_low_after_code_restart", {31'd0, tree_ready}, 32'd0);
    send_hdr(4'b0001, 1'b0);
    send_leaf(4'd2, 4'd1, 16'h0001, 1'b0, 1'b0);
    send_leaf(4'hE, 4'd2, 16'h0006, 1'b1, 1'b0);
    send_payload(16'h0001, 3);
    tick();

    // Asynchronous Reset during LENGTH.
    do_restart();
    send_hdr(4'b0000, 1'b0);
    put_bits(16'h000B, 4, 1'b0);
    put_bits(16'h0001, 2, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("async_rst_wr_idx", {28'd0, wr_idx}, 32'd0);
    chk("async_rst_wr_code", {16'd0, wr_code}, 32'd0);
    chk("async_rst_wr_len", {27'd0, wr_len}, 32'd0);
    chk("async_rst_wr_value", {28'd0, wr_value}, 32'd0);
    chk("async_rst_tree_ready", {31'd0, tree_ready}, 32'd0);
    chk("async_rst_err", {31'd0, err}, 32'd0);
    tick();
    Reset = 1'b1;
    tick();
    send_hdr(4'b0000, 1'b0);
    send_leaf(4'hD, 4'd3, 16'h0009, 1'b1, 1'b0);
    send_payload(16'h0002, 2);
    tick();
    tick();

    chk("wr_queue_drained", exp_q.size(), 32'd0);
    chk("dec_queue_drained", dec_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hf_tree_loader.md
# hf_tree_loader

Serial Huffman tree-descriptor parser and sequencer for the 4-bit-symbol Huffman decompressor. It hunts the incoming bitstream for a sync marker and parses the leaf descriptors that follow. It programs the decompressor's 16-entry leaf table through a write port, then raises `tree_ready` and forwards the remaining bits to the decoder. It owns the build-tree/decode phase change for the decompression path.

## Interface
- `SYNC`, default 8'hA5: sync marker, MSB first.
- `MAX_LEN`, default 16: largest legal code length, in the range 1..16.

- `CLK` in 1: clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `restart` in 1: synchronous pulse; abandons the current tree and returns to HUNT.
- `bit_in` in 1: serial stream bit.
- `bit_valid` in 1: `bit_in` is accepted this cycle. The block never stalls, so there is no ready signal.
- `wr_en` out 1: one-cycle leaf-table write strobe.
- `wr_idx` out 4: leaf slot, 0..15, assigned in arrival order.
- `wr_code` out 16: code, right-aligned, upper bits zero.
- `wr_len` out 5: code length, 1..16.
- `wr_value` out 4: decoded symbol for the leaf.
- `tree_ready` out 1: table complete; the decoder may run.
- `dec_bit` out 1: equals `bit_in`, passed through to the decoder.
- `dec_valid` out 1: `bit_valid & tree_ready`, combinational.
- `err` out 1: sticky descriptor error.

## Operation
- Stream format, all fields MSB first:
  - `SYNC` (8 bits).
  - CNT (4 bits) = leaf count − 1.
  - Then for each leaf: VAL (4 bits), LEN (4 bits) = length − 1, then LEN+1 code bits.
- States: HUNT, COUNT, VALUE, LENGTH, CODE, READY, ERR.
- HUNT:
  - An 8-bit shift register takes each accepted bit.
  - Go to COUNT on the accepted bit where {sh[6:0], bit_in} == SYNC.
  - Overlapping prefixes are honoured: 1010_0101 is detected even when preceded by extra 1/0 bits.
- COUNT: collect 4 bits into the leaves-remaining counter, then go to VALUE.
- VALUE: collect 4 bits into the value register, then go to LENGTH.
- LENGTH:
  - Collect 4 bits; the length is field + 1.
  - Go to CODE, clearing the code register.
- CODE:
  - Shift each bit in: code <= {code[14:0], bit_in}.
  - When the count reaches the length, register a write, increment the slot index, and decrement the leaves-remaining counter.
  - Next state: READY if this was the last leaf, else VALUE.
- READY:
  - `tree_ready` = 1.
  - All accepted bits pass to the decoder.
  - The FSM holds here until `restart` or `Reset`.
- ERR:
  - `err` = 1; bits are ignored; `tree_ready` = 0.
  - The FSM holds here until `restart` or `Reset`.
- `restart`:
  - Takes priority over `bit_valid` in the same cycle.
  - Next state HUNT; clears `tree_ready`, `err`, the shift register, counters and slot index.
  - A write in flight that cycle still completes.
- Cycles with `bit_valid` low change no state.
- Slot indices not written keep the table's reset contents. This block never clears the table.
- The 4-bit CNT cannot exceed 16 leaves, so slot overflow is impossible.

## Timing
- Reset value of every output is 0: `wr_en`, `wr_idx`, `wr_code`, `wr_len`, `wr_value`, `tree_ready`, `err`, and therefore `dec_valid`. The FSM resets to HUNT.
- Write latency:
  - `wr_en` and its fields are registered.
  - They are valid for exactly one cycle, starting the cycle after the final code bit is accepted.
- Throughput: bits may arrive back-to-back during the write cycle with no loss. The next VALUE bit is accepted in that cycle.
- `tree_ready` rises on the same edge as the last leaf's `wr_en`. The first bit presented in that cycle is forwarded, so the first payload bit is not lost.
- Mid-operation `Reset`: all state and outputs return to reset values immediately (asynchronous).

## Configuration
- `HF_TREE_LENCHK_EN` defined:
  - A LEN field giving length > `MAX_LEN` sends the FSM to ERR on the 4th LEN bit.
  - No write is issued for that leaf.
- Not defined:
  - All lengths 1..16 are accepted.
  - `err` is tied to 0 and the ERR state is unreachable.

## Test plan
- Reset, then 1010_0101, CNT=0001, leaf (VAL=3, LEN=0000, code 0), leaf (VAL=9, LEN=0001, code 10) back-to-back:
  - `wr_en` pulses with idx0/code 0x0000/len1/val3.
  - Then idx1/code 0x0002/len2/val9.
  - `tree_ready` rises with the second write.
  - Subsequent bits appear on `dec_bit` with `dec_valid`.
- Noise 0x5A, 0xFF before SYNC, and `bit_valid` gaps inside fields:
  - No writes before the marker.
  - Parsed results are identical to the gap-free run.
- CNT=1111, 16 leaves each of length 4:
  - 16 writes, idx 0..15.
  - `tree_ready` rises only with the idx15 write.
- With `HF_TREE_LENCHK_EN` and `MAX_LEN`=8, LEN=1000:
  - `err`=1, no write, `tree_ready`=0.
  - A `restart` pulse clears `err`.
  - A valid tree then loads.
- `restart` asserted in the same cycle as `bit_valid` during CODE:
  - Bit discarded, FSM in HUNT.
  - The next SYNC reloads from idx0.
- `Reset` low during LENGTH:
  - All outputs 0 immediately.
  - A tree sent after release loads normally.
